trng_word_packer: RTL and testbench



---
 rtl/trng_pkg.sv | 20 ++
 rtl/vn_debias.sv | 54 +++++
 rtl/trng_word_packer.sv | 202 ++++++++++++++++++++
 tb/tb_trng_word_packer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Package  : trng_pkg
// Brief    : Shared widths and FSM encoding for the TRNG word packer.
// Revision : 1.0 - initial release
// ============================================================================
package trng_pkg;

  localparam int WORD_W = 64;
  localparam int CNT_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2,
    ST_GAP     = 2'd3
  } trng_state_e;

endpackage
`default_nettype wire

// File: rtl/vn_debias.sv
`default_nettype none
// ============================================================================
// Module   : vn_debias
// Brief    : Von Neumann debiaser on a strobed bit stream (01->0, 10->1,
//            00/11 dropped); optional pass-through when disabled.
// Revision : 1.0 - initial release
// ============================================================================
module vn_debias #(
  parameter int VN_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic strobe,
  input  logic bit_in,
  output logic bit_valid,
  output logic bit_out
);

  generate
    if (VN_EN != 0) begin : g_vn
      logic have_first;
      logic first_bit;

      // Hold the first sample of each pair; a half pair is forgotten on clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          have_first <= 1'b0;
          first_bit  <= 1'b0;
        end else if (clear) begin
          have_first <= 1'b0;
        end else if (strobe) begin
          if (!have_first) begin
            have_first <= 1'b1;
            first_bit  <= bit_in;
          end else begin
            have_first <= 1'b0;
          end
        end
      end

      // The output bit of an unequal pair is simply its first sample.
      assign bit_valid = strobe && have_first && (first_bit != bit_in);
      assign bit_out   = first_bit;
    end else begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = clk ^ rst_n ^ clear;
      assign bit_valid     = strobe;
      assign bit_out       = bit_in;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : trng_word_packer
// Brief    : Samples a ring-oscillator bit, optionally debiases it, packs
//            64-bit words and presents them with a stretched ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module trng_word_packer
  import trng_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int VN_EN      = 1,
  parameter int READY_HOLD = 4,
  parameter int READY_GAP  = 2
) (
  input  logic              clk,
  input  logic              trng_rst_n,
  input  logic              enable_TRO,
  input  logic              raw_bit,
  output logic              ro_enable,
  output logic [WORD_W-1:0] random_reg,
  output logic              rng_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  words_out
);

  localparam int              PH_MAX    = (READY_HOLD > READY_GAP) ? READY_HOLD : READY_GAP;
  localparam int              PH_W      = $clog2(PH_MAX);
  localparam logic [7:0]      DIV_LAST  = 8'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(READY_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(READY_GAP - 1);

  logic              sync_q1;
  logic              sync_q2;
  logic [7:0]        div_cnt;
  logic [1:0]        warm_cnt;
  logic              strobe;
  logic              warm_done;
  logic              keep_strobe;
  logic              vn_valid;
  logic              vn_bit;
  // Bit 63 of the partial word is never needed: it is shifted out as the
  // word completes, so only 63 bits are kept between emitted bits.
  logic [WORD_W-2:0] shift_reg;
  logic [5:0]        bit_cnt;
  logic [WORD_W-1:0] packed_word;
  logic              word_done;
  trng_state_e       state;
  trng_state_e       state_next;
  logic [PH_W-1:0]   ph_cnt;
  logic              present;
  logic              use_pend;
  logic              pend_valid;
  logic [WORD_W-1:0] pend_word;

  assign strobe      = ro_enable && (div_cnt == DIV_LAST);
  assign warm_done   = (warm_cnt == 2'd2);
  assign keep_strobe = strobe && warm_done && enable_TRO;
  assign packed_word = {shift_reg, vn_bit};
  assign word_done   = vn_valid && enable_TRO && (bit_cnt == 6'd63);

  // Oscillator enable lags the request by one cycle; raw bit crosses via two flops.
  always_ff @(posedge clk or negedge trng_rst_n) begin
    if (!trng_rst_n) begin
      ro_enable <= 1'b0;
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
    end else begin
      ro_enable <= enable_TRO;
      sync_q1   <= raw_bit;
      sync_q2   <= sync_q1;
    end
  end

  // Sample divider and warm-up discard, both held at zero while the oscillator is off.
  always_ff @(posedge clk or negedge trng_rst_n) begin
    if (!trng_rst_n) begin
      div_cnt  <= 8'd0;
      warm_cnt <= 2'd0;
    end else if (!ro_enable) begin
      div_cnt  <= 8'd0;
      warm_cnt <= 2'd0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      if (strobe && !warm_done) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  vn_debias #(
    .VN_EN (VN_EN)
  ) u_vn_debias (
    .clk       (clk),
    .rst_n     (trng_rst_n),
    .clear     (!ro_enable),
    .strobe    (keep_strobe),
    .bit_in    (sync_q2),
    .bit_valid (vn_valid),
    .bit_out   (vn_bit)
  );

  // Shift emitted bits in MSB-first; dropping the run request discards the partial word.
  always_ff @(posedge clk or negedge trng_rst_n) begin
    if (!trng_rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= 6'd0;
    end else if (!enable_TRO) begin
      shift_reg <= '0;
      bit_cnt   <= 6'd0;
    end else if (vn_valid) begin
      shift_reg <= packed_word[WORD_W-2:0];
      bit_cnt   <= bit_cnt + 6'd1;
    end
  end

  // State register; the phase counter restarts on every state change.
  always_ff @(posedge clk or negedge trng_rst_n) begin
    if (!trng_rst_n) begin
      state  <= ST_IDLE;
      ph_cnt <= '0;
    end else begin
      state  <= state_next;
      ph_cnt <= (state_next != state) ? '0 : ph_cnt + 1'b1;
    end
  end

  // Next state and presentation decision.
  always_comb begin
    state_next = state;
    present    = 1'b0;
    use_pend   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ro_enable) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!enable_TRO) begin
          state_next = ST_IDLE;
        end else if (word_done) begin
          state_next = ST_PRESENT;
          present    = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (ph_cnt == HOLD_LAST) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (ph_cnt == GAP_LAST) begin
          if (!(ro_enable && enable_TRO)) begin
            state_next = ST_IDLE;
          end else if (pend_valid) begin
            state_next = ST_PRESENT;
            present    = 1'b1;
            use_pend   = 1'b1;
          end else if (word_done) begin
            state_next = ST_PRESENT;
            present    = 1'b1;
          end else begin
            state_next = ST_COLLECT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Presented word, ready pulse, word count, pending buffer and sticky overrun.
  always_ff @(posedge clk or negedge trng_rst_n) begin
    if (!trng_rst_n) begin
      random_reg <= '0;
      rng_ready  <= 1'b0;
      words_out  <= '0;
      overrun    <= 1'b0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
    end else begin
      if (present) begin
        random_reg <= use_pend ? pend_word : packed_word;
        rng_ready  <= 1'b1;
        if (words_out != '1) words_out <= words_out + CNT_W'(1);
      end else if (state == ST_PRESENT && state_next == ST_GAP) begin
        rng_ready <= 1'b0;
      end

      if (!enable_TRO) begin
        pend_valid <= 1'b0;
      end else if (word_done && !(present && !use_pend)) begin
        if (!pend_valid || use_pend) begin
          pend_valid <= 1'b1;
          pend_word  <= packed_word;
        end else begin
          overrun <= 1'b1;
        end
      end else if (use_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_word_packer
// Brief    : Bench for trng_word_packer; three parameter sets share stimulus
//            and are each compared against a word-schedule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_word_packer;

  logic        clk = 1'b0;
  logic        trng_rst_n = 1'b1;
  logic        enable_TRO = 1'b0;
  logic        raw_bit = 1'b0;

  logic        d_ro  [3];
  logic [63:0] d_reg [3];
  logic        d_rdy [3];
  logic        d_ovr [3];
  logic [19:0] d_cnt [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trng_word_packer #(.SAMPLE_DIV(4), .VN_EN(1), .READY_HOLD(4), .READY_GAP(2)) u_dut_a (
    .clk(clk), .trng_rst_n(trng_rst_n), .enable_TRO(enable_TRO), .raw_bit(raw_bit),
    .ro_enable(d_ro[0]), .random_reg(d_reg[0]), .rng_ready(d_rdy[0]),
    .overrun(d_ovr[0]), .words_out(d_cnt[0]));

  trng_word_packer #(.SAMPLE_DIV(1), .VN_EN(0), .READY_HOLD(4), .READY_GAP(2)) u_dut_b (
    .clk(clk), .trng_rst_n(trng_rst_n), .enable_TRO(enable_TRO), .raw_bit(raw_bit),
    .ro_enable(d_ro[1]), .random_reg(d_reg[1]), .rng_ready(d_rdy[1]),
    .overrun(d_ovr[1]), .words_out(d_cnt[1]));

  trng_word_packer #(.SAMPLE_DIV(1), .VN_EN(0), .READY_HOLD(40), .READY_GAP(40)) u_dut_c (
    .clk(clk), .trng_rst_n(trng_rst_n), .enable_TRO(enable_TRO), .raw_bit(raw_bit),
    .ro_enable(d_ro[2]), .random_reg(d_reg[2]), .rng_ready(d_rdy[2]),
    .overrun(d_ovr[2]), .words_out(d_cnt[2]));

  function automatic int p_div(int i);  return (i == 0) ? 4 : 1;  endfunction
  function automatic bit p_vn(int i);   return (i == 0);          endfunction
  function automatic int p_hold(int i); return (i == 2) ? 40 : 4; endfunction
  function automatic int p_gap(int i);  return (i == 2) ? 40 : 2; endfunction

  // Reference model state: sample stream, bit accumulation, presentation schedule.
  longint      cyc;
  bit          en_prev, raw_h1, raw_h2;
  int          run_len    [3];
  bit          have_first [3];
  bit          first_b    [3];
  logic [63:0] m_word     [3];
  int          m_cnt      [3];
  bit          busy       [3];
  longint      busy_until [3];
  longint      pres_at    [3];
  bit          have_pend  [3];
  logic [63:0] pend_w     [3];
  logic        e_rdy      [3];
  logic [63:0] e_reg      [3];
  logic [19:0] e_cnt      [3];
  logic        e_ovr      [3];
  logic        e_ro;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; en_prev = 0; raw_h1 = 0; raw_h2 = 0; e_ro = 0;
    for (int i = 0; i < 3; i++) begin
      run_len[i] = 0; have_first[i] = 0; first_b[i] = 0; m_word[i] = '0; m_cnt[i] = 0;
      busy[i] = 0; busy_until[i] = 0; pres_at[i] = 0; have_pend[i] = 0; pend_w[i] = '0;
      e_rdy[i] = 0; e_reg[i] = '0; e_cnt[i] = '0; e_ovr[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit samp);
    bit          emit, ebit, done, present;
    logic [63:0] pword;
    emit = 0; ebit = 0; done = 0; present = 0; pword = '0;
    // Strobe k of an enabled run falls on the k*SAMPLE_DIV-th enabled edge;
    // strobes 1 and 2 are warm-up and thrown away.
    if (en_prev) run_len[i]++; else run_len[i] = 0;
    if (!en_prev) begin
      have_first[i] = 0;
    end else if (enable_TRO && (run_len[i] % p_div(i) == 0) && (run_len[i] / p_div(i) >= 3)) begin
      if (!p_vn(i)) begin
        emit = 1; ebit = samp;
      end else if (!have_first[i]) begin
        have_first[i] = 1; first_b[i] = samp;
      end else begin
        have_first[i] = 0;
        if (first_b[i] != samp) begin emit = 1; ebit = first_b[i]; end
      end
    end
    if (!enable_TRO) begin
      m_word[i] = '0; m_cnt[i] = 0;
    end else if (emit) begin
      m_word[i] = {m_word[i][62:0], ebit};
      m_cnt[i]++;
      if (m_cnt[i] == 64) begin m_cnt[i] = 0; done = 1; end
    end
    // A presentation occupies HOLD+GAP edges; the pending word goes out as it ends.
    if (busy[i] && cyc == busy_until[i]) begin
      busy[i] = 0;
      if (en_prev && enable_TRO && have_pend[i]) begin
        present = 1; pword = pend_w[i]; have_pend[i] = 0;
      end
    end
    if (done) begin
      if (!busy[i] && !present) begin present = 1; pword = m_word[i]; end
      else if (!have_pend[i]) begin have_pend[i] = 1; pend_w[i] = m_word[i]; end
      else e_ovr[i] = 1;
    end
    if (!enable_TRO) have_pend[i] = 0;
    if (present) begin
      busy[i] = 1; pres_at[i] = cyc; busy_until[i] = cyc + p_hold(i) + p_gap(i);
      e_reg[i] = pword;
      if (e_cnt[i] != 20'hFFFFF) e_cnt[i] = e_cnt[i] + 20'd1;
    end
    e_rdy[i] = busy[i] && ((cyc - pres_at[i]) < longint'(p_hold(i)));
  endtask

  // Advance the model on every clock edge taken outside reset.
  always @(posedge clk) begin : p_model
    bit samp;
    if (trng_rst_n) begin
      samp = raw_h2;
      cyc++;
      for (int i = 0; i < 3; i++) model_step(i, samp);
      e_ro = enable_TRO;
      en_prev = enable_TRO; raw_h2 = raw_h1; raw_h1 = raw_bit;
    end
  end

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("ro_enable[%0d]", i),  64'(d_ro[i]),  64'(e_ro));
      check_val($sformatf("rng_ready[%0d]", i),  64'(d_rdy[i]), 64'(e_rdy[i]));
      check_val($sformatf("random_reg[%0d]", i), d_reg[i],      e_reg[i]);
      check_val($sformatf("words_out[%0d]", i),  64'(d_cnt[i]), 64'(e_cnt[i]));
      check_val($sformatf("overrun[%0d]", i),    64'(d_ovr[i]), 64'(e_ovr[i]));
    end
  endtask

  // Check at the falling edge, then drive the next inputs.
  task automatic tick(input bit en, input bit rb);
    @(negedge clk);
    compare_all();
    enable_TRO = en;
    raw_bit    = rb;
  endtask

  initial begin
    bit         en;
    int         waited;
    logic [7:0] pat;
    model_reset();
    #1 trng_rst_n = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    trng_rst_n = 1'b1;

    // Steady random entropy.
    for (int k = 0; k < 3000; k++) tick(1'b1, 1'($urandom_range(0, 1)));

    // Random run-request drops and re-raises.
    en = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 299) == 0) en = !en;
      tick(en, 1'($urandom_range(0, 1)));
    end

    // Constant ones: words every 64 cycles; the long-pulse instance must drop one.
    for (int k = 0; k < 1500; k++) tick(1'b1, 1'b1);
    check_val("overrun_long_pulse", 64'(d_ovr[2]), 64'd1);
    check_val("overrun_short_pulse", 64'(d_ovr[1]), 64'd0);

    // Repeating pair pattern 01,10,00,11, each sample held for four cycles.
    pat = 8'b0110_0011;
    for (int k = 0; k < 800; k++) tick(1'b1, pat[7 - ((k / 4) % 8)]);

    // Asynchronous reset while a ready pulse is high.
    waited = 0;
    while (d_rdy[1] !== 1'b1 && waited < 500) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      waited++;
    end
    check_val("ready_before_reset", 64'(d_rdy[1]), 64'd1);
    #2 trng_rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("async_rst_ready[%0d]", i), 64'(d_rdy[i]), 64'd0);
      check_val($sformatf("async_rst_reg[%0d]", i),   d_reg[i],      64'd0);
      check_val($sformatf("async_rst_words[%0d]", i), 64'(d_cnt[i]), 64'd0);
      check_val($sformatf("async_rst_ovr[%0d]", i),   64'(d_ovr[i]), 64'd0);
    end
    repeat (3) tick(1'b1, 1'($urandom_range(0, 1)));
    trng_rst_n = 1'b1;
    for (int k = 0; k < 2000; k++) tick(1'b1, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
